// File: rtl/prog_instr_memory.sv
// Loadable LC2K instruction memory for the fetch stage.
// Programs stream in through the load port starting at word 0; fetches use a
// valid/ready request/response handshake with one cycle of registered read
// latency. Fetches at or beyond the loaded program length return HALT_WORD
// with rsp_oor set.
module prog_instr_memory #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       PC_W      = 32,
  parameter int unsigned       DEPTH     = 64,
  parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(32'd25165824),
  localparam int unsigned      AW        = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_busy,
  output logic              load_err,
  output logic [AW:0]       prog_len,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [PC_W-1:0]   req_pc,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_instr,
  output logic              rsp_oor
);

  // The range check is done at the wider of the PC and length widths so a
  // large PC never wraps into the loaded region.
  localparam int unsigned CW       = (PC_W > AW + 1) ? PC_W : AW + 1;
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [AW:0]   FULL_LEN = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RESP
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]       prog_len_q, prog_len_d;
  logic              load_err_q, load_err_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_instr_q, rsp_instr_d;
  logic              rsp_oor_q, rsp_oor_d;

  logic              mem_we;
  logic              req_fire;
  logic              pc_in_range;
  logic [CW-1:0]     pc_ext;
  logic [CW-1:0]     len_ext;
  logic [DATA_W-1:0] fetch_word;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Request handshake and the word a fetch would return this cycle.
  always_comb begin
    req_ready   = ((state_q == IDLE) && !load_start) ||
                  ((state_q == RESP) && rsp_ready);
    req_fire    = req_valid && req_ready;
    pc_ext      = CW'(req_pc);
    len_ext     = CW'(prog_len_q);
    pc_in_range = (pc_ext < len_ext);
    fetch_word  = pc_in_range ? mem_q[req_pc[AW-1:0]] : HALT_WORD;
  end

  // Next-state logic for the load/fetch controller and response registers.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    prog_len_d  = prog_len_q;
    load_err_d  = load_err_q;
    rsp_valid_d = rsp_valid_q;
    rsp_instr_d = rsp_instr_q;
    rsp_oor_d   = rsp_oor_q;
    mem_we      = 1'b0;

    case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d    = LOAD;
          wr_ptr_d   = '0;
          prog_len_d = '0;
          load_err_d = 1'b0;
        end else if (req_fire) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_instr_d = fetch_word;
          rsp_oor_d   = !pc_in_range;
        end
      end

      LOAD: begin
        if (load_valid) begin
          mem_we = 1'b1;
          if (load_last) begin
            state_d    = IDLE;
            prog_len_d = {1'b0, wr_ptr_q} + 1'b1;
          end else if (wr_ptr_q == LAST_PTR) begin
            // Memory is full without a last beat: keep what fits, flag it.
            state_d    = IDLE;
            prog_len_d = FULL_LEN;
            load_err_d = 1'b1;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
      end

      RESP: begin
        if (req_fire) begin
          rsp_valid_d = 1'b1;
          rsp_instr_d = fetch_word;
          rsp_oor_d   = !pc_in_range;
        end else if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller and response registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      prog_len_q  <= '0;
      load_err_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_instr_q <= '0;
      rsp_oor_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      prog_len_q  <= prog_len_d;
      load_err_q  <= load_err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_instr_q <= rsp_instr_d;
      rsp_oor_q   <= rsp_oor_d;
    end
  end

  // Program storage; contents survive reset and are gated by prog_len instead.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= load_data;
    end
  end

  assign load_busy = (state_q == LOAD);
  assign load_err  = load_err_q;
  assign prog_len  = prog_len_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_instr = rsp_instr_q;
  assign rsp_oor   = rsp_oor_q;

endmodule

// File: tb/tb_prog_instr_memory.sv
// Bench for prog_instr_memory (DEPTH=8): directed program load/fetch steps
// followed by randomized traffic, all checked against a transaction-level
// reference model of the memory, program length and pending response.
module tb_prog_instr_memory;

  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] HALT  = 32'd25165824;

  logic        clk        = 1'b0;
  logic        rst_n      = 1'b1;
  logic        load_start = 1'b0;
  logic        load_valid = 1'b0;
  logic [31:0] load_data  = '0;
  logic        load_last  = 1'b0;
  logic        req_valid  = 1'b0;
  logic [31:0] req_pc     = '0;
  logic        rsp_ready  = 1'b0;
  logic        load_busy;
  logic        load_err;
  logic [3:0]  prog_len;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_instr;
  logic        rsp_oor;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] m_mem [DEPTH];
  bit          m_loading;
  bit          m_pend;
  bit          m_err;
  int unsigned m_ptr;
  int unsigned m_len;
  logic [31:0] m_instr;
  bit          m_oor;

  logic [31:0] prog [7];

  always #5 clk = ~clk;

  prog_instr_memory #(
    .DATA_W(32),
    .PC_W  (32),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_start(load_start),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_last (load_last),
    .load_busy (load_busy),
    .load_err  (load_err),
    .prog_len  (prog_len),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_pc    (req_pc),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_instr (rsp_instr),
    .rsp_oor   (rsp_oor)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs();
    chk("load_busy", {31'd0, load_busy}, {31'd0, m_loading});
    chk("load_err", {31'd0, load_err}, {31'd0, m_err});
    chk("prog_len", {28'd0, prog_len}, m_len);
    chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_pend});
    if (m_pend) begin
      chk("rsp_instr", rsp_instr, m_instr);
      chk("rsp_oor", {31'd0, rsp_oor}, {31'd0, m_oor});
    end
  endtask

  // One clock cycle: drive inputs, check req_ready, advance model, check registers.
  task automatic cycle(input bit ls, input bit lv, input logic [31:0] ld, input bit ll,
                       input bit rv, input logic [31:0] pc, input bit rr);
    bit exp_rdy;
    bit fire;
    load_start = ls;
    load_valid = lv;
    load_data  = ld;
    load_last  = ll;
    req_valid  = rv;
    req_pc     = pc;
    rsp_ready  = rr;
    #1;
    exp_rdy = !m_loading && ((!m_pend && !ls) || (m_pend && rr));
    chk("req_ready", {31'd0, req_ready}, {31'd0, exp_rdy});
    fire = rv && exp_rdy;
    if (m_loading) begin
      if (lv) begin
        m_mem[m_ptr] = ld;
        if (ll) begin
          m_len     = m_ptr + 1;
          m_loading = 1'b0;
        end else if (m_ptr == DEPTH - 1) begin
          m_len     = DEPTH;
          m_err     = 1'b1;
          m_loading = 1'b0;
        end else begin
          m_ptr++;
        end
      end
    end else if (!m_pend && ls) begin
      m_loading = 1'b1;
      m_ptr     = 0;
      m_len     = 0;
      m_err     = 1'b0;
    end else if (fire) begin
      m_pend = 1'b1;
      if (pc < m_len) begin
        m_instr = m_mem[pc % DEPTH];
        m_oor   = 1'b0;
      end else begin
        m_instr = HALT;
        m_oor   = 1'b1;
      end
    end else if (m_pend && rr) begin
      m_pend = 1'b0;
    end
    @(posedge clk);
    #1;
    check_regs();
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_last  = 1'b0;
    req_valid  = 1'b0;
    rsp_ready  = 1'b0;
    #2;
    m_loading = 1'b0;
    m_pend    = 1'b0;
    m_err     = 1'b0;
    m_len     = 0;
    m_ptr     = 0;
    chk("rst_load_busy", {31'd0, load_busy}, 32'd0);
    chk("rst_load_err", {31'd0, load_err}, 32'd0);
    chk("rst_prog_len", {28'd0, prog_len}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_instr", rsp_instr, 32'd0);
    chk("rst_rsp_oor", {31'd0, rsp_oor}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    prog[0] = 32'd8519687;
    prog[1] = 32'd22216704;
    prog[2] = 32'd16777219;
    prog[3] = 32'd29360128;
    prog[4] = 32'd29360128;
    prog[5] = 32'd1179649;
    prog[6] = 32'd25165824;

    #1;
    // T1: reset
    do_reset();

    // T2: load the 7-word program with a gap between beats
    cycle(1, 0, '0, 0, 1, 32'd0, 1);
    for (int i = 0; i < 7; i++) begin
      if (i == 3) cycle(0, 0, 32'hdead_beef, 1, 0, '0, 0);
      cycle(0, 1, prog[i], (i == 6), 0, '0, 0);
    end
    chk("t2_prog_len", {28'd0, prog_len}, 32'd7);
    chk("t2_load_busy", {31'd0, load_busy}, 32'd0);

    // T3: back-to-back fetches pc=0..6
    for (int i = 0; i < 7; i++) begin
      cycle(0, 0, '0, 0, 1, i, 1);
      chk("t3_instr", rsp_instr, prog[i]);
      chk("t3_oor", {31'd0, rsp_oor}, 32'd0);
    end
    cycle(0, 0, '0, 0, 0, '0, 1);

    // T4: out of range at the length boundary and with the PC MSB set
    cycle(0, 0, '0, 0, 1, 32'd7, 1);
    chk("t4_instr_len", rsp_instr, HALT);
    chk("t4_oor_len", {31'd0, rsp_oor}, 32'd1);
    cycle(0, 0, '0, 0, 1, 32'h8000_0000, 1);
    chk("t4_instr_msb", rsp_instr, HALT);
    chk("t4_oor_msb", {31'd0, rsp_oor}, 32'd1);
    cycle(0, 0, '0, 0, 0, '0, 1);

    // T5: backpressure for 3 cycles, then same-cycle acceptance on release
    cycle(0, 0, '0, 0, 1, 32'd2, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, '0, 0, 1, 32'd3, 0);
      chk("t5_held", rsp_instr, prog[2]);
    end
    cycle(0, 0, '0, 0, 1, 32'd3, 1);
    chk("t5_next", rsp_instr, prog[3]);
    cycle(0, 0, '0, 0, 0, '0, 1);

    // T6a: 9 beats without load_last truncate at DEPTH
    cycle(1, 0, '0, 0, 0, '0, 0);
    for (int i = 0; i < 9; i++) cycle(0, 1, 32'h100 + i, 0, 0, '0, 0);
    chk("t6_prog_len", {28'd0, prog_len}, 32'd8);
    chk("t6_load_err", {31'd0, load_err}, 32'd1);
    cycle(0, 0, '0, 0, 1, 32'd7, 1);
    chk("t6_last_word", rsp_instr, 32'h107);
    cycle(0, 0, '0, 0, 1, 32'd8, 1);
    chk("t6_oor_depth", {31'd0, rsp_oor}, 32'd1);
    cycle(0, 0, '0, 0, 0, '0, 1);

    // T6b: reset in the middle of a load
    cycle(1, 0, '0, 0, 0, '0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 32'h200 + i, 0, 0, '0, 0);
    do_reset();
    cycle(0, 0, '0, 0, 1, 32'd0, 1);
    chk("t6b_instr", rsp_instr, HALT);
    chk("t6b_oor", {31'd0, rsp_oor}, 32'd1);
    cycle(0, 0, '0, 0, 0, '0, 1);

    // Randomized traffic: loads of varying length, fetches, backpressure
    for (int n = 0; n < 800; n++) begin
      bit          ls;
      bit          lv;
      bit          ll;
      bit          rv;
      bit          rr;
      logic [31:0] pc;
      ls = ($urandom_range(0, 19) == 0);
      lv = ($urandom_range(0, 3) != 0);
      ll = ($urandom_range(0, 5) == 0);
      rv = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) pc = $urandom;
      else pc = $urandom_range(0, 9);
      cycle(ls, lv, $urandom, ll, rv, pc, rr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
